// File: rtl/lb1_line_buf_if.sv
// Pixel stream bundle for the FCL1 line buffer: upstream pixel input, downstream
// pixel output with indices, and the frame status flags.
interface lb1_line_buf_if #(
    parameter int DATA_WIDTH       = 8,
    parameter int CNT_ROW_WIDTH    = 3,
    parameter int CNT_COLUMN_WIDTH = 2
);
    logic                        pxl_in_valid;
    logic [DATA_WIDTH-1:0]       pxl_in_data;
    logic                        pxl_in_ready;
    logic                        pxl_out_valid;
    logic [DATA_WIDTH-1:0]       pxl_out_data;
    logic                        pxl_out_ready;
    logic [CNT_ROW_WIDTH-1:0]    pxl_out_row;
    logic [CNT_COLUMN_WIDTH-1:0] pxl_out_col;
    logic                        pxl_out_last;
    logic                        lb_full_o;
    logic                        frame_done_o;

    // Stream source and sink side (drives pixels in, accepts pixels out)
    modport master (
        output pxl_in_valid, pxl_in_data, pxl_out_ready,
        input  pxl_in_ready, pxl_out_valid, pxl_out_data, pxl_out_row,
               pxl_out_col, pxl_out_last, lb_full_o, frame_done_o
    );

    // Line buffer side
    modport slave (
        input  pxl_in_valid, pxl_in_data, pxl_out_ready,
        output pxl_in_ready, pxl_out_valid, pxl_out_data, pxl_out_row,
               pxl_out_col, pxl_out_last, lb_full_o, frame_done_o
    );
endinterface

// File: rtl/lb1_line_buf.sv
// Line buffer: captures one frame of pixels in row-inner order, then replays it
// in the same order to the FCL1 MAC stage with a valid/ready handshake.
module lb1_line_buf #(
    parameter int DATA_WIDTH       = 8,
    parameter int CNT_ROW_WIDTH    = 3,
    parameter int CNT_COLUMN_WIDTH = 2
) (
    input  logic            lb1_clk,
    input  logic            lb1_rst,
    lb1_line_buf_if.slave   bus
);
    localparam int ADDR_WIDTH = CNT_ROW_WIDTH + CNT_COLUMN_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                      state_reg;
    logic [CNT_ROW_WIDTH-1:0]    wr_row_reg;
    logic [CNT_COLUMN_WIDTH-1:0] wr_col_reg;
    logic                        out_valid_reg;
    logic [DATA_WIDTH-1:0]       out_data_reg;
    logic [CNT_ROW_WIDTH-1:0]    out_row_reg;
    logic [CNT_COLUMN_WIDTH-1:0] out_col_reg;
    logic                        out_last_reg;
    logic                        full_reg;
    logic                        done_reg;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_next;
    logic [ADDR_WIDTH-1:0] rd_sel;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  in_accept;
    logic                  fill_last;
    logic                  out_hs;

    assign wr_addr   = {wr_col_reg, wr_row_reg};
    assign rd_next   = {out_col_reg, out_row_reg} + 1'b1;
    assign in_accept = bus.pxl_in_valid && (state_reg == FILL);
    assign fill_last = in_accept && (&wr_addr);
    assign out_hs    = out_valid_reg && bus.pxl_out_ready;

    // Entering DRAIN loads address 0; inside DRAIN the register advances one address
    assign rd_sel = (state_reg == FILL) ? '0 : rd_next;

    // Single-entry buffer: address 0 is still being written on the entry cycle
    assign rd_word = (state_reg == FILL && DEPTH == 1) ? bus.pxl_in_data : mem[rd_sel];

    always_ff @(posedge lb1_clk) begin
        if (!lb1_rst && in_accept) begin
            mem[wr_addr] <= bus.pxl_in_data;
        end
    end

    always_ff @(posedge lb1_clk) begin
        if (lb1_rst) begin
            state_reg     <= FILL;
            wr_row_reg    <= '0;
            wr_col_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_row_reg   <= '0;
            out_col_reg   <= '0;
            out_last_reg  <= 1'b0;
            full_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                FILL: begin
                    if (in_accept) begin
                        wr_row_reg <= wr_row_reg + 1'b1;
                        if (&wr_row_reg) begin
                            wr_col_reg <= wr_col_reg + 1'b1;
                        end
                    end
                    if (fill_last) begin
                        state_reg     <= DRAIN;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= rd_word;
                        out_row_reg   <= '0;
                        out_col_reg   <= '0;
                        out_last_reg  <= (DEPTH == 1);
                        full_reg      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (out_last_reg) begin
                            state_reg     <= FILL;
                            out_valid_reg <= 1'b0;
                            out_row_reg   <= '0;
                            out_col_reg   <= '0;
                            out_last_reg  <= 1'b0;
                            full_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            out_data_reg <= rd_word;
                            out_row_reg  <= rd_next[CNT_ROW_WIDTH-1:0];
                            out_col_reg  <= rd_next[ADDR_WIDTH-1:CNT_ROW_WIDTH];
                            out_last_reg <= &rd_next;
                        end
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign bus.pxl_in_ready  = (state_reg == FILL) && !lb1_rst;
    assign bus.pxl_out_valid = out_valid_reg;
    assign bus.pxl_out_data  = out_data_reg;
    assign bus.pxl_out_row   = out_row_reg;
    assign bus.pxl_out_col   = out_col_reg;
    assign bus.pxl_out_last  = out_last_reg;
    assign bus.lb_full_o     = full_reg;
    assign bus.frame_done_o  = done_reg;
endmodule
